// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_if
//  Description : Request/result bundle for the sequential multiply/divide
//                unit. The master issues start/ALUControl/a/b and observes
//                busy/done/hi/lo/div_by_zero; the slave is the unit itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if;
    logic        start;
    logic [2:0]  ALUControl;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    modport master (
        output start, ALUControl, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, ALUControl, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Sequential signed 32x32 multiplier (shift-add, 32 cycles)
//                and optional signed 32/32 restoring divider (32 cycles,
//                1 cycle on divide-by-zero). Both work on operand
//                magnitudes and apply the signs when the result is written.
//                Result lands in hi/lo on the edge entering FIN and holds
//                until the next completion or reset.
//  Config      : define MDU_DIV_EN to compile in the divider. Without it,
//                code 3'b110 is a no-op and div_by_zero is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit (
    input  wire logic           clk,
    input  wire logic           reset,
    mult_div_unit_if.slave      bus
);

    localparam logic [2:0] C_OP_MULT = 3'b101;
`ifdef MDU_DIV_EN
    localparam logic [2:0] C_OP_DIV  = 3'b110;
`endif
    localparam logic [4:0] C_LAST    = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef MDU_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_FIN  = 2'd3
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;        // iteration index, 0..31
    logic        r_neg_res;    // product / quotient must be negated
    logic [63:0] r_acc;        // {partial product, remaining multiplier bits}
    logic [31:0] r_mcand;      // multiplicand magnitude
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    // Operand magnitudes; 32'h80000000 maps to itself, which is the correct
    // unsigned magnitude 2^31.
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    assign w_a_mag = bus.a[31] ? (32'd0 - bus.a) : bus.a;
    assign w_b_mag = bus.b[31] ? (32'd0 - bus.b) : bus.b;

    // One shift-add step: conditionally add the multiplicand into the upper
    // half (keeping the carry) and shift the whole accumulator right.
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [63:0] w_mul_prod;
    assign w_mul_sum  = r_acc[0] ? ({1'b0, r_acc[63:32]} + {1'b0, r_mcand})
                                 : {1'b0, r_acc[63:32]};
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};
    assign w_mul_prod = r_neg_res ? (64'd0 - w_mul_next) : w_mul_next;

`ifdef MDU_DIV_EN
    logic [31:0] r_a;          // raw dividend, returned in hi on divide-by-zero
    logic        r_b_zero;
    logic        r_neg_rem;    // remainder takes the sign of the dividend
    logic [31:0] r_divisor;    // divisor magnitude
    logic [31:0] r_rem;        // partial remainder
    logic [31:0] r_quo;        // dividend bits shifting out, quotient bits in
    logic        r_dbz;

    // One restoring step: bring down the next dividend bit, try to subtract
    // the divisor, keep the difference only when it did not borrow. The
    // shifted value is below 2*divisor <= 2^32, so 33 bits suffice and the
    // surviving remainder always fits back into 32 bits.
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic        w_div_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_quo_final;
    logic [31:0] w_rem_final;
    assign w_div_shift = {r_rem, r_quo[31]};
    assign w_div_diff  = w_div_shift - {1'b0, r_divisor};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_divisor});
    assign w_rem_next  = w_div_ge ? w_div_diff[31:0] : w_div_shift[31:0];
    assign w_quo_next  = {r_quo[30:0], w_div_ge};
    assign w_quo_final = r_neg_res ? (32'd0 - w_quo_next) : w_quo_next;
    assign w_rem_final = r_neg_rem ? (32'd0 - w_rem_next) : w_rem_next;

    assign bus.div_by_zero = r_dbz;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    // Control FSM and datapath: accept in IDLE, iterate in MUL/DIV, write the
    // result on the edge into FIN, pulse done for one cycle, return to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_neg_res <= 1'b0;
            r_acc     <= 64'd0;
            r_mcand   <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef MDU_DIV_EN
            r_a       <= 32'd0;
            r_b_zero  <= 1'b0;
            r_neg_rem <= 1'b0;
            r_divisor <= 32'd0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_dbz     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && (bus.ALUControl == C_OP_MULT)) begin
                        r_acc     <= {32'd0, w_b_mag};
                        r_mcand   <= w_a_mag;
                        r_neg_res <= bus.a[31] ^ bus.b[31];
                        r_cnt     <= 5'd0;
                        r_busy    <= 1'b1;
                        r_state   <= S_MUL;
                    end
`ifdef MDU_DIV_EN
                    else if (bus.start && (bus.ALUControl == C_OP_DIV)) begin
                        r_a       <= bus.a;
                        r_b_zero  <= (bus.b == 32'd0);
                        r_neg_res <= bus.a[31] ^ bus.b[31];
                        r_neg_rem <= bus.a[31];
                        r_divisor <= w_b_mag;
                        r_rem     <= 32'd0;
                        r_quo     <= w_a_mag;
                        r_cnt     <= 5'd0;
                        r_busy    <= 1'b1;
                        r_state   <= S_DIV;
                    end
`endif
                end

                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == C_LAST) begin
                        r_hi    <= w_mul_prod[63:32];
                        r_lo    <= w_mul_prod[31:0];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end
                end

`ifdef MDU_DIV_EN
                S_DIV: begin
                    if (r_b_zero) begin
                        // Divide-by-zero finishes after a single DIV cycle.
                        r_hi    <= r_a;
                        r_lo    <= 32'hFFFF_FFFF;
                        r_dbz   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == C_LAST) begin
                            r_hi    <= w_rem_final;
                            r_lo    <= w_quo_final;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                end
`endif

                S_FIN: begin
                    r_done  <= 1'b0;
`ifdef MDU_DIV_EN
                    r_dbz   <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Directed self-checking bench for mult_div_unit. Expected
//                results are hand-computed constants. Divider vectors are
//                active when MDU_DIV_EN is defined; otherwise code 3'b110
//                is checked to be ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mult_div_unit_if u_if ();

    mult_div_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation, scramble operands and pulse a stray MULT request
    // while it runs, then check latency (in cycles counted from the accept
    // cycle), busy length, result and that everything holds one cycle later.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dbz);
        int lat;
        int nbusy;
        u_if.start      = 1'b1;
        u_if.ALUControl = op;
        u_if.a          = a;
        u_if.b          = b;
        @(posedge clk); #1;
        u_if.start      = 1'b0;
        u_if.ALUControl = 3'b110;
        u_if.a          = 32'hDEAD_BEEF;
        u_if.b          = 32'd0;
        lat   = 0;
        nbusy = 0;
        while (!u_if.done && lat < 60) begin
            if (u_if.busy) nbusy++;
            if (lat == 5) begin
                u_if.start      = 1'b1;
                u_if.ALUControl = 3'b101;
                u_if.a          = 32'h1234_5678;
                u_if.b          = 32'h0000_0003;
            end
            if (lat == 8) u_if.start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        u_if.start = 1'b0;
        chk({tag, "_done_cycle"}, 64'(lat + 1), 64'(exp_cyc));
        chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_cyc - 1));
        chk({tag, "_hi"}, 64'(u_if.hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(u_if.lo), 64'(exp_lo));
        chk({tag, "_dbz"}, 64'(u_if.div_by_zero), 64'(exp_dbz));
        chk({tag, "_busy_at_done"}, 64'(u_if.busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(u_if.done), 64'd0);
        chk({tag, "_dbz_pulse"}, 64'(u_if.div_by_zero), 64'd0);
        chk({tag, "_hi_hold"}, 64'(u_if.hi), 64'(exp_hi));
        chk({tag, "_lo_hold"}, 64'(u_if.lo), 64'(exp_lo));
    endtask

    // Present a request in IDLE that must be ignored.
    task automatic ignored_req(input string tag, input logic [2:0] op,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        u_if.start      = 1'b1;
        u_if.ALUControl = op;
        u_if.a          = 32'd11;
        u_if.b          = 32'd0;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        chk({tag, "_busy"}, 64'(u_if.busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_busy2"}, 64'(u_if.busy), 64'd0);
        chk({tag, "_done"}, 64'(u_if.done), 64'd0);
        chk({tag, "_dbz"}, 64'(u_if.div_by_zero), 64'd0);
        chk({tag, "_hi"}, 64'(u_if.hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(u_if.lo), 64'(exp_lo));
    endtask

    initial begin
        int done_seen;
        n_cmp           = 0;
        n_err           = 0;
        reset           = 1'b1;
        u_if.start      = 1'b0;
        u_if.ALUControl = 3'b000;
        u_if.a          = 32'd0;
        u_if.b          = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(u_if.busy), 64'd0);
        chk("rst_done", 64'(u_if.done), 64'd0);
        chk("rst_hi", 64'(u_if.hi), 64'd0);
        chk("rst_lo", 64'(u_if.lo), 64'd0);
        chk("rst_dbz", 64'(u_if.div_by_zero), 64'd0);
        reset = 1'b0;

        // First request goes in on the first edge after reset release.
        run_op("mul_7x6", 3'b101, 32'd7, 32'd6, 33, 32'd0, 32'd42, 1'b0);
        ignored_req("nop_010", 3'b010, 32'd0, 32'd42);
        run_op("mul_m3x5", 3'b101, 32'hFFFF_FFFD, 32'd5, 33,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("mul_min_sq", 3'b101, 32'h8000_0000, 32'h8000_0000, 33,
               32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("mul_max_sq", 3'b101, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33,
               32'h3FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("mul_m1xm1", 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33,
               32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op("mul_minx1", 3'b101, 32'h8000_0000, 32'd1, 33,
               32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

`ifdef MDU_DIV_EN
        run_op("div_m7d2", 3'b110, 32'hFFFF_FFF9, 32'd2, 33,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_9d0", 3'b110, 32'd9, 32'd0, 2,
               32'd9, 32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 33,
               32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("div_7dm2", 3'b110, 32'd7, 32'hFFFF_FFFE, 33,
               32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("div_100d7", 3'b110, 32'd100, 32'd7, 33,
               32'd2, 32'd14, 1'b0);
        run_op("div_m9d0", 3'b110, 32'hFFFF_FFF7, 32'd0, 2,
               32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
`else
        ignored_req("nop_110", 3'b110, 32'hFFFF_FFFF, 32'h8000_0000);
`endif

        // Abort a MULT after 10 cycles: no done, hi/lo cleared, back to IDLE.
        u_if.start      = 1'b1;
        u_if.ALUControl = 3'b101;
        u_if.a          = 32'd7;
        u_if.b          = 32'd6;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort_busy_before", 64'(u_if.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 64'(u_if.busy), 64'd0);
        chk("abort_done", 64'(u_if.done), 64'd0);
        chk("abort_hi", 64'(u_if.hi), 64'd0);
        chk("abort_lo", 64'(u_if.lo), 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (u_if.done || u_if.busy) done_seen++;
        end
        chk("abort_quiet", 64'(done_seen), 64'd0);
        run_op("mul_after_abort", 3'b101, 32'd7, 32'd6, 33, 32'd0, 32'd42, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
